pc_fetch_ctrl: RTL and testbench
================================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rstd  in  1  reset; SHALL be asynchronous and active-low.
REQ-004 taken  in  1  branch-condition result from the branch comparator.
REQ-005 br_valid  in  1  a conditional branch resolves this cycle.
REQ-006 jump  in  1  j/jal resolves this cycle.
REQ-007 jr  in  1  jr resolves this cycle.
REQ-008 ctl_pc4  in  32  PC+4 of the resolving control instruction.
REQ-009 offset  in  16  signed branch word offset.
REQ-010 jtarget  in  26  jump word index.
REQ-011 jr_addr  in  32  register jump address.
REQ-012 stall  in  1  downstream cannot accept inst this cycle.
REQ-013 imem_req  out  1  instruction memory request.
REQ-014 imem_addr  out  32  request address.
REQ-015 imem_ack  in  1  memory data valid; completes the request.
REQ-016 imem_rdata  in  32  fetched word.
REQ-017 inst  out  32  instruction delivered downstream.
REQ-018 inst_pc  out  32  address of inst.
REQ-019 inst_valid  out  1  inst/inst_pc valid.

Function
REQ-020 redirect SHALL be jr | jump | (br_valid & taken); target priority SHALL be jr > jump > branch.
REQ-021 Targets SHALL be: jr -> {jr_addr[31:2],2'b00}; jump -> {ctl_pc4[31:28],jtarget,2'b00}; branch -> ctl_pc4 + sign-extended {offset,2'b00}, 32-bit modulo sum.
REQ-022 States SHALL be IDLE, FETCH, HOLD, DRAIN; internal fetch_pc register holds the next fetch address.
REQ-023 IDLE: imem_req=0; next state SHALL be FETCH with imem_addr<=fetch_pc, imem_req<=1.
REQ-024 FETCH: imem_req=1; imem_addr SHALL stay stable until the imem_ack cycle.
REQ-025 FETCH, ack, no redirect: inst<=imem_rdata, inst_pc<=imem_addr, inst_valid<=1, fetch_pc<=imem_addr+4 (wraps at 2^32), imem_req<=0, next HOLD.
REQ-026 HOLD, no redirect, stall=1: all outputs SHALL hold, no request issued.
REQ-027 HOLD, no redirect, stall=0: instruction consumed at this edge; inst_valid<=0, imem_addr<=fetch_pc, imem_req<=1, next FETCH.
REQ-028 Redirect in IDLE or HOLD: fetch_pc and imem_addr<=target, inst_valid<=0, imem_req<=1, next FETCH; redirect SHALL override stall.
REQ-029 Redirect in FETCH with ack same cycle: imem_rdata SHALL be discarded, inst_valid stays 0, next FETCH at target.
REQ-030 Redirect in FETCH without ack: fetch_pc<=target, imem_req and imem_addr unchanged, next DRAIN.
REQ-031 DRAIN: imem_req=1 at old address; a further redirect SHALL overwrite fetch_pc; on ack data SHALL be discarded and next state FETCH at fetch_pc (ack and redirect together: newest target used).
REQ-032 inst_valid SHALL be 1 only in HOLD; stall SHALL be ignored outside HOLD.

Reset
REQ-033 rstd low SHALL immediately force IDLE, imem_req=0, inst_valid=0, inst=0, inst_pc=0, imem_addr=RESET_PC, fetch_pc=RESET_PC.
REQ-034 Reset mid-request SHALL abandon the outstanding request; a late imem_ack after reset SHALL be ignored in IDLE.

Verification
REQ-035 Reset release, RESET_PC=0, ack one cycle after each req, stall=0 -> requests at 0x0, 0x4, 0x8; inst_pc matches each; inst_valid pulses one cycle per word.
REQ-036 HOLD with inst=0x8C010004, stall=1 for 3 cycles -> inst/inst_pc unchanged, imem_req=0 throughout; next request at inst_pc+4 after stall drops.
REQ-037 HOLD, br_valid=1, taken=1, ctl_pc4=0x00000104, offset=0xFFFE -> next cycle imem_req=1, imem_addr=0x000000FC, inst_valid=0.
REQ-038 FETCH at 0x20, branch taken to 0x80, ack delayed 3 cycles -> DRAIN, imem_addr stays 0x20, returned word not delivered, then request at 0x80.
REQ-039 jr=1 jr_addr=0x00400003, jump=1, br_valid=1 taken=1 same cycle -> next request at 0x00400000.
REQ-040 rstd low while imem_req=1 -> imem_req=0 and imem_addr=RESET_PC before next clock edge; first post-release request at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, issues one instruction-memory
// request at a time, and redirects on jr/jump/taken-branch.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstd,
    input  logic        taken,
    input  logic        br_valid,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] ctl_pc4,
    input  logic [15:0] offset,
    input  logic [25:0] jtarget,
    input  logic [31:0] jr_addr,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10,
        DRAIN = 2'b11
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_imem_addr;
    logic        r_imem_req;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_inst_valid;

    logic [31:0] w_fetch_pc_nxt;
    logic [31:0] w_imem_addr_nxt;
    logic        w_imem_req_nxt;
    logic [31:0] w_inst_nxt;
    logic [31:0] w_inst_pc_nxt;
    logic        w_inst_valid_nxt;

    logic        w_redirect;
    logic [31:0] w_br_target;
    logic [31:0] w_target;
    logic [31:0] w_resume_pc;

    // Redirect decode and target selection (jr beats jump beats branch).
    always_comb begin
        w_redirect  = jr | jump | (br_valid & taken);
        w_br_target = ctl_pc4 + {{14{offset[15]}}, offset, 2'b00};
        if (jr) begin
            w_target = {jr_addr[31:2], 2'b00};
        end else if (jump) begin
            w_target = {ctl_pc4[31:28], jtarget, 2'b00};
        end else begin
            w_target = w_br_target;
        end
        // Where to fetch once a stale response has been retired.
        if (w_redirect) begin
            w_resume_pc = w_target;
        end else begin
            w_resume_pc = r_fetch_pc;
        end
    end

    // Next-state and next-output computation; every register holds by default.
    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_imem_addr_nxt  = r_imem_addr;
        w_imem_req_nxt   = r_imem_req;
        w_inst_nxt       = r_inst;
        w_inst_pc_nxt    = r_inst_pc;
        w_inst_valid_nxt = r_inst_valid;
        case (r_state)
            IDLE: begin
                w_state_nxt      = FETCH;
                w_imem_req_nxt   = 1'b1;
                w_inst_valid_nxt = 1'b0;
                w_fetch_pc_nxt   = w_resume_pc;
                w_imem_addr_nxt  = w_resume_pc;
            end
            FETCH: begin
                if (imem_ack) begin
                    if (w_redirect) begin
                        w_state_nxt     = FETCH;
                        w_fetch_pc_nxt  = w_target;
                        w_imem_addr_nxt = w_target;
                    end else begin
                        w_state_nxt      = HOLD;
                        w_inst_nxt       = imem_rdata;
                        w_inst_pc_nxt    = r_imem_addr;
                        w_inst_valid_nxt = 1'b1;
                        w_fetch_pc_nxt   = r_imem_addr + 32'd4;
                        w_imem_req_nxt   = 1'b0;
                    end
                end else if (w_redirect) begin
                    // The in-flight word is now stale; wait for it in DRAIN.
                    w_state_nxt    = DRAIN;
                    w_fetch_pc_nxt = w_target;
                end else begin
                    w_state_nxt = FETCH;
                end
            end
            HOLD: begin
                if (w_redirect) begin
                    w_state_nxt      = FETCH;
                    w_fetch_pc_nxt   = w_target;
                    w_imem_addr_nxt  = w_target;
                    w_imem_req_nxt   = 1'b1;
                    w_inst_valid_nxt = 1'b0;
                end else if (!stall) begin
                    w_state_nxt      = FETCH;
                    w_imem_addr_nxt  = r_fetch_pc;
                    w_imem_req_nxt   = 1'b1;
                    w_inst_valid_nxt = 1'b0;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    w_state_nxt     = FETCH;
                    w_fetch_pc_nxt  = w_resume_pc;
                    w_imem_addr_nxt = w_resume_pc;
                    w_imem_req_nxt  = 1'b1;
                end else if (w_redirect) begin
                    w_state_nxt    = DRAIN;
                    w_fetch_pc_nxt = w_target;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            default: begin
                w_state_nxt      = IDLE;
                w_imem_req_nxt   = 1'b0;
                w_inst_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            r_state      <= IDLE;
            r_fetch_pc   <= RESET_PC;
            r_imem_addr  <= RESET_PC;
            r_imem_req   <= 1'b0;
            r_inst       <= 32'h0000_0000;
            r_inst_pc    <= 32'h0000_0000;
            r_inst_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_imem_addr  <= w_imem_addr_nxt;
            r_imem_req   <= w_imem_req_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_pc    <= w_inst_pc_nxt;
            r_inst_valid <= w_inst_valid_nxt;
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_imem_addr;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_valid = r_inst_valid;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl: directed scenarios plus a randomized run
// compared against a transaction-level reference model.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rstd;
    logic        taken, br_valid, jump, jr, stall, imem_ack;
    logic [31:0] ctl_pc4, jr_addr, imem_rdata;
    logic [15:0] offset;
    logic [25:0] jtarget;
    logic        imem_req, inst_valid;
    logic [31:0] imem_addr, inst, inst_pc;

    int checks = 0;
    int errors = 0;

    pc_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rstd(rstd), .taken(taken), .br_valid(br_valid),
        .jump(jump), .jr(jr), .ctl_pc4(ctl_pc4), .offset(offset),
        .jtarget(jtarget), .jr_addr(jr_addr), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst(inst), .inst_pc(inst_pc),
        .inst_valid(inst_valid)
    );

    always #5 clk = ~clk;

    // Reference model: request outstanding / stale / instruction held.
    logic        m_req, m_have, m_discard;
    logic [31:0] m_addr, m_next, m_inst, m_inst_pc;
    logic        m_redir;
    logic [31:0] m_tgt;

    always_comb begin
        m_redir = jr || jump || (br_valid && taken);
        if (jr)        m_tgt = jr_addr & ~32'h0000_0003;
        else if (jump) m_tgt = (ctl_pc4 & 32'hF000_0000) | (32'(jtarget) << 2);
        else           m_tgt = ctl_pc4 + 32'(int'($signed(offset)) * 4);
    end

    always @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            m_req <= 1'b0; m_have <= 1'b0; m_discard <= 1'b0;
            m_addr <= RESET_PC; m_next <= RESET_PC;
            m_inst <= 32'h0; m_inst_pc <= 32'h0;
        end else if (m_have) begin
            if (m_redir) begin
                m_have <= 1'b0; m_req <= 1'b1; m_addr <= m_tgt; m_next <= m_tgt;
            end else if (!stall) begin
                m_have <= 1'b0; m_req <= 1'b1; m_addr <= m_next;
            end
        end else if (m_req) begin
            if (imem_ack) begin
                if (m_discard || m_redir) begin
                    m_discard <= 1'b0;
                    m_addr <= m_redir ? m_tgt : m_next;
                    m_next <= m_redir ? m_tgt : m_next;
                end else begin
                    m_have <= 1'b1; m_inst <= imem_rdata; m_inst_pc <= m_addr;
                    m_next <= m_addr + 32'd4; m_req <= 1'b0;
                end
            end else if (m_redir) begin
                m_next <= m_tgt; m_discard <= 1'b1;
            end
        end else begin
            m_req <= 1'b1;
            m_addr <= m_redir ? m_tgt : m_next;
            m_next <= m_redir ? m_tgt : m_next;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_ctl();
        taken = 1'b0; br_valid = 1'b0; jump = 1'b0; jr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks += 5;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0h want 0", imem_req); end
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h want 0", inst_valid); end
        if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %08h want 0", inst); end
        if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc got %08h want 0", inst_pc); end
        if (imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr got %08h want %08h", imem_addr, RESET_PC); end
        rstd = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] d;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks += 3;
            if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_req[%0d] got %0h want 1", i, imem_req); end
            if (imem_addr !== 32'(i * 4)) begin errors++; $display("FAIL seq_addr[%0d] got %08h want %08h", i, imem_addr, 32'(i * 4)); end
            if (inst_valid !== 1'b0) begin errors++; $display("FAIL seq_valid_low[%0d] got %0h want 0", i, inst_valid); end
            d = $urandom; imem_ack = 1'b1; imem_rdata = d;
            tick();
            imem_ack = 1'b0;
            checks += 4;
            if (inst_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %0h want 1", i, inst_valid); end
            if (inst !== d) begin errors++; $display("FAIL seq_inst[%0d] got %08h want %08h", i, inst, d); end
            if (inst_pc !== 32'(i * 4)) begin errors++; $display("FAIL seq_inst_pc[%0d] got %08h want %08h", i, inst_pc, 32'(i * 4)); end
            if (imem_req !== 1'b0) begin errors++; $display("FAIL seq_req_low[%0d] got %0h want 0", i, imem_req); end
        end
    endtask

    task automatic test_stall();
        tick();
        checks += 1;
        if (imem_addr !== 32'h0000_000C) begin errors++; $display("FAIL stall_pre_addr got %08h want 0000000c", imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h8C01_0004; stall = 1'b1;
        tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks += 4;
            if (inst !== 32'h8C01_0004) begin errors++; $display("FAIL stall_inst[%0d] got %08h want 8c010004", i, inst); end
            if (inst_pc !== 32'h0000_000C) begin errors++; $display("FAIL stall_inst_pc[%0d] got %08h want 0000000c", i, inst_pc); end
            if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got %0h want 0", i, imem_req); end
            if (inst_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %0h want 1", i, inst_valid); end
        end
        stall = 1'b0;
        tick();
        checks += 3;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL stall_release_req got %0h want 1", imem_req); end
        if (imem_addr !== 32'h0000_0010) begin errors++; $display("FAIL stall_release_addr got %08h want 00000010", imem_addr); end
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid got %0h want 0", inst_valid); end
    endtask

    task automatic test_branch();
        imem_ack = 1'b1; imem_rdata = $urandom;
        tick();
        imem_ack = 1'b0;
        checks += 1;
        if (inst_pc !== 32'h0000_0010) begin errors++; $display("FAIL br_hold_pc got %08h want 00000010", inst_pc); end
        br_valid = 1'b1; taken = 1'b1; ctl_pc4 = 32'h0000_0104; offset = 16'hFFFE; stall = 1'b1;
        tick();
        clear_ctl(); stall = 1'b0;
        checks += 3;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL br_req got %0h want 1", imem_req); end
        if (imem_addr !== 32'h0000_00FC) begin errors++; $display("FAIL br_addr got %08h want 000000fc", imem_addr); end
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL br_valid_out got %0h want 0", inst_valid); end
    endtask

    task automatic test_redirect_drain();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        jump = 1'b1; jtarget = 26'h000_0008; ctl_pc4 = 32'h0000_0100;
        tick();
        clear_ctl(); imem_ack = 1'b0;
        checks += 2;
        if (imem_addr !== 32'h0000_0020) begin errors++; $display("FAIL ackredir_addr got %08h want 00000020", imem_addr); end
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL ackredir_valid got %0h want 0", inst_valid); end
        br_valid = 1'b1; taken = 1'b1; ctl_pc4 = 32'h0000_0024; offset = 16'h0017;
        tick();
        clear_ctl();
        for (int i = 0; i < 3; i++) begin
            checks += 3;
            if (imem_req !== 1'b1) begin errors++; $display("FAIL drain_req[%0d] got %0h want 1", i, imem_req); end
            if (imem_addr !== 32'h0000_0020) begin errors++; $display("FAIL drain_addr[%0d] got %08h want 00000020", i, imem_addr); end
            if (inst_valid !== 1'b0) begin errors++; $display("FAIL drain_valid[%0d] got %0h want 0", i, inst_valid); end
            if (i < 2) tick();
        end
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        imem_ack = 1'b0;
        checks += 3;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL drain_done_valid got %0h want 0", inst_valid); end
        if (imem_req !== 1'b1) begin errors++; $display("FAIL drain_done_req got %0h want 1", imem_req); end
        if (imem_addr !== 32'h0000_0080) begin errors++; $display("FAIL drain_done_addr got %08h want 00000080", imem_addr); end
    endtask

    task automatic test_priority();
        imem_ack = 1'b1; imem_rdata = $urandom;
        tick();
        imem_ack = 1'b0;
        checks += 1;
        if (inst_pc !== 32'h0000_0080) begin errors++; $display("FAIL prio_hold_pc got %08h want 00000080", inst_pc); end
        jr = 1'b1; jr_addr = 32'h0040_0003; jump = 1'b1; jtarget = 26'h3FF_FFFF;
        br_valid = 1'b1; taken = 1'b1; ctl_pc4 = 32'h0000_0200; offset = 16'h0004;
        tick();
        clear_ctl();
        checks += 2;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL prio_req got %0h want 1", imem_req); end
        if (imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL prio_addr got %08h want 00400000", imem_addr); end
    endtask

    task automatic test_reset_mid();
        #2 rstd = 1'b0;
        #1;
        checks += 3;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL rstmid_req got %0h want 0", imem_req); end
        if (imem_addr !== RESET_PC) begin errors++; $display("FAIL rstmid_addr got %08h want %08h", imem_addr, RESET_PC); end
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0h want 0", inst_valid); end
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = $urandom;
        rstd = 1'b1;
        tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks += 3;
            if (imem_req !== 1'b1) begin errors++; $display("FAIL rstmid_post_req[%0d] got %0h want 1", i, imem_req); end
            if (imem_addr !== RESET_PC) begin errors++; $display("FAIL rstmid_post_addr[%0d] got %08h want %08h", i, imem_addr, RESET_PC); end
            if (inst_valid !== 1'b0) begin errors++; $display("FAIL rstmid_post_valid[%0d] got %0h want 0", i, inst_valid); end
            if (i == 0) tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            checks += 5;
            if (imem_req !== m_req) begin errors++; $display("FAIL rnd_req[%0d] got %0h want %0h", i, imem_req, m_req); end
            if (imem_addr !== m_addr) begin errors++; $display("FAIL rnd_addr[%0d] got %08h want %08h", i, imem_addr, m_addr); end
            if (inst_valid !== m_have) begin errors++; $display("FAIL rnd_valid[%0d] got %0h want %0h", i, inst_valid, m_have); end
            if (inst !== m_inst) begin errors++; $display("FAIL rnd_inst[%0d] got %08h want %08h", i, inst, m_inst); end
            if (inst_pc !== m_inst_pc) begin errors++; $display("FAIL rnd_inst_pc[%0d] got %08h want %08h", i, inst_pc, m_inst_pc); end
            stall      = ($urandom_range(0, 2) == 0);
            imem_ack   = imem_req && ($urandom_range(0, 2) == 0);
            imem_rdata = $urandom;
            jr         = ($urandom_range(0, 15) == 0);
            jump       = ($urandom_range(0, 15) == 0);
            br_valid   = ($urandom_range(0, 5) == 0);
            taken      = 1'($urandom);
            ctl_pc4    = $urandom;
            offset     = 16'($urandom);
            jtarget    = 26'($urandom);
            jr_addr    = $urandom;
            rstd       = ($urandom_range(0, 299) != 0);
            tick();
        end
        rstd = 1'b1;
    endtask

    initial begin
        rstd = 1'b0; stall = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        ctl_pc4 = 32'h0; offset = 16'h0; jtarget = 26'h0; jr_addr = 32'h0;
        clear_ctl();
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_redirect_drain();
        test_priority();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
